tensor_stream_gen: RTL and testbench



---
 rtl/tensor_gen_pkg.sv | 23 ++
 rtl/gen_lfsr32.sv | 34 +++
 rtl/tensor_stream_gen.sv | 159 +++++++++++++++
 tb/tb_tensor_stream_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tensor_gen_pkg.sv
// Shared definitions for the tensor stream generator:
// data-mode encodings, the LFSR polynomial and the control state type.
package tensor_gen_pkg;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Right-shifting Galois step: the bit shifted out selects the feedback taps.
  function automatic logic [31:0] lfsrStep(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/gen_lfsr32.sv
// 32-bit Galois LFSR with load and step enables. next_o exposes the value the
// register takes at the coming edge so callers can register data derived from it.
module gen_lfsr32
  import tensor_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        step_i,
  output logic [31:0] next_o
);

  logic [31:0] lfsr_q;

  // An all-zero state would lock the LFSR, so a zero load becomes 1.
  always_comb begin
    next_o = lfsr_q;
    if (load_i) begin
      next_o = (load_val_i == 32'd0) ? 32'd1 : load_val_i;
    end else if (step_i) begin
      next_o = lfsrStep(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 32'd0;
    end else begin
      lfsr_q <= next_o;
    end
  end

endmodule

// File: rtl/tensor_stream_gen.sv
// Raster pixel-word source for the core input FIFO: one CHANNELS-lane word per
// cycle under full-based backpressure, with eol/eof flags, abort and done pulse.
module tensor_stream_gen
  import tensor_gen_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 416,
  parameter int HEIGHT   = 416
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [1:0]                 mode_i,
  input  logic [DATA_W-1:0]          seed_i,
  input  logic                       full_i,
  output logic [CHANNELS*DATA_W-1:0] data_o,
  output logic                       valid_o,
  output logic                       eol_o,
  output logic                       eof_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = $clog2(WIDTH * HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_e                      state_q, state_d;
  logic [XW-1:0]               x_q, x_d;
  logic [YW-1:0]               y_q, y_d;
  logic [PW-1:0]               p_q, p_d;
  logic [1:0]                  mode_q, mode_d;
  logic [DATA_W-1:0]           seed_q, seed_d;
  logic [CHANNELS*DATA_W-1:0]  data_q, data_d;
  logic                        valid_q, valid_d, eol_q, eol_d, eof_q, eof_d;
  logic                        busy_q, busy_d, done_q, done_d;
  logic [31:0]                 lfsrNext;
  logic                        startAcc, xfer;

  assign startAcc = (state_q == ST_IDLE) && start_i;
  assign xfer     = (state_q == ST_RUN) && valid_q && !full_i && !abort_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort takes priority over a transfer, including the final one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (abort_i)           state_d = ST_IDLE;
        else if (xfer && eof_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Post-transfer raster position; outputs are registered from these values.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    p_d    = p_q;
    mode_d = mode_q;
    seed_d = seed_q;
    if (startAcc) begin
      x_d    = '0;
      y_d    = '0;
      p_d    = '0;
      mode_d = mode_i;
      seed_d = seed_i;
    end else if (xfer) begin
      p_d = p_q + PW'(1);
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  gen_lfsr32 u_lfsr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (startAcc),
    .load_val_i (32'(seed_i)),
    .step_i     (xfer),
    .next_o     (lfsrNext)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [DATA_W-1:0] laneVal;
    always_comb begin
      laneVal = seed_d;
      case (mode_d)
        MODE_RAMP:  laneVal = DATA_W'(p_d) * DATA_W'(CHANNELS) + DATA_W'(c);
        MODE_LFSR:  laneVal = lfsrNext[DATA_W-1:0] ^ DATA_W'(c);
        MODE_CHECK: laneVal = (x_d[0] ^ y_d[0]) ? ~seed_d : seed_d;
        default:    laneVal = seed_d;
      endcase
    end
    assign data_d[c*DATA_W +: DATA_W] = laneVal;
  end

  always_comb begin
    valid_d = (state_d == ST_RUN);
    busy_d  = valid_d;
    done_d  = (state_d == ST_DONE);
    eol_d   = valid_d && (x_d == X_LAST);
    eof_d   = eol_d && (y_d == Y_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      mode_q  <= '0;
      seed_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign eol_o   = eol_q;
  assign eof_o   = eof_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_tensor_stream_gen.sv
// Scoreboard bench for tensor_stream_gen on a 4x2 frame of 3 x 32-bit lanes:
// frames push expected words, a negedge monitor pops them on every transfer.
module tb_tensor_stream_gen;

  localparam int DW = 32;
  localparam int CH = 3;
  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          startI = 1'b0;
  logic          abortI = 1'b0;
  logic          fullI = 1'b0;
  logic [1:0]    modeI = 2'd0;
  logic [DW-1:0] seedI = '0;
  logic [95:0]   dataO;
  logic          validO, eolO, eofO, busyO, doneO;

  typedef struct packed {
    logic [95:0] data;
    logic        eol;
    logic        eof;
  } expT;

  expT expQ[$];
  expT monE;
  int  checkCount = 0;
  int  passCount = 0;
  int  xferCount = 0;

  tensor_stream_gen #(
    .DATA_W(DW), .CHANNELS(CH), .WIDTH(W), .HEIGHT(H)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .start_i (startI),
    .abort_i (abortI),
    .mode_i  (modeI),
    .seed_i  (seedI),
    .full_i  (fullI),
    .data_o  (dataO),
    .valid_o (validO),
    .eol_o   (eolO),
    .eof_o   (eofO),
    .busy_o  (busyO),
    .done_o  (doneO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic logic [31:0] lfsrModel(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [95:0] pixelWord(input logic [1:0] m, input logic [31:0] s,
                                            input int pix, input logic [31:0] lfsr);
    logic [95:0] w;
    int x, y;
    x = pix % W;
    y = pix / W;
    w = '0;
    for (int c = 0; c < CH; c++) begin
      case (m)
        2'd0: w[c*32 +: 32] = s;
        2'd1: w[c*32 +: 32] = 32'(pix * CH + c);
        2'd2: w[c*32 +: 32] = lfsr ^ 32'(c);
        default: w[c*32 +: 32] = (((x ^ y) & 1) != 0) ? ~s : s;
      endcase
    end
    return w;
  endfunction

  task automatic pushFrame(input logic [1:0] m, input logic [31:0] s, input int count);
    logic [31:0] lfsr;
    expT e;
    lfsr = (s == 32'd0) ? 32'd1 : s;
    for (int pix = 0; pix < count; pix++) begin
      e.data = pixelWord(m, s, pix, lfsr);
      e.eol  = (pix % W) == (W - 1);
      e.eof  = (pix == NPIX - 1);
      expQ.push_back(e);
      lfsr = lfsrModel(lfsr);
    end
  endtask

  // Transfer monitor: a word offered with full and abort low is consumed at the next edge.
  always @(negedge clk) begin
    if (rstN && validO && !fullI && !abortI) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedWord: got %h, expected no transfer", dataO);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wordData", dataO, monE.data);
        checkOutput("wordEol", eolO, monE.eol);
        checkOutput("wordEof", eofO, monE.eof);
      end
      xferCount++;
    end
  end

  // cutKind: 0 = full frame, 1 = abort when pixel cutAt is offered, 2 = reset at pixel cutAt.
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] s, input logic [95:0] firstWord,
                               input int stallAt, input int stallLen, input int cutAt, input int cutKind);
    int  base, cyc, validCycles, stallLeft;
    bit  sawDone;
    pushFrame(m, s, (cutKind == 0) ? NPIX : cutAt);
    base = xferCount;
    @(posedge clk); #1;
    startI = 1'b1; modeI = m; seedI = s;
    @(posedge clk); #1;
    startI = 1'b0;
    checkOutput("busyAfterStart", busyO, 1);
    checkOutput("firstWord", dataO, firstWord);
    cyc = 1; validCycles = 0; stallLeft = stallLen; sawDone = 0;
    while (!sawDone && cyc < 60) begin
      if (doneO) begin
        sawDone = 1;
        checkOutput("busyWithDone", busyO, 0);
        checkOutput("validWithDone", validO, 0);
      end else begin
        if (validO) validCycles++;
        if (cutKind != 0 && (xferCount - base) == cutAt) begin
          fullI = 1'b0;
          if (cutKind == 1) begin
            abortI = 1'b1;
            @(posedge clk); #1;
            abortI = 1'b0;
            checkOutput("validAfterAbort", validO, 0);
            checkOutput("busyAfterAbort", busyO, 0);
            for (int k = 0; k < 3; k++) begin
              checkOutput("noDoneAfterAbort", doneO, 0);
              @(posedge clk); #1;
            end
          end else begin
            rstN = 1'b0;
            #1;
            checkOutput("resetData", dataO, 0);
            checkOutput("resetFlags", {validO, eolO, eofO, busyO, doneO}, 0);
            @(posedge clk); #1;
            checkOutput("resetHeld", {validO, busyO, doneO}, 0);
            rstN = 1'b1;
          end
          checkOutput("cutTransfers", xferCount - base, cutAt);
          checkOutput("cutScoreboardEmpty", expQ.size(), 0);
          return;
        end
        if ((xferCount - base) == stallAt && stallLeft > 0) begin
          fullI = 1'b1;
          stallLeft--;
          checkOutput("stallHold", dataO, pixelWord(m, s, stallAt, 32'd0));
        end else begin
          fullI = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    fullI = 1'b0;
    if (!sawDone) begin
      checkCount++;
      $display("[TB] FAIL doneTimeout: got no done after %0d cycles, expected done", cyc);
    end else begin
      checkOutput("validCycles", validCycles, NPIX + stallLen);
      checkOutput("doneCycle", cyc, NPIX + stallLen + 1);
    end
    @(posedge clk); #1;
    checkOutput("donePulseWidth", doneO, 0);
    checkOutput("idleAfterDone", {validO, busyO}, 0);
    checkOutput("frameTransfers", xferCount - base, NPIX);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
  endtask

  initial begin
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetDataInit", dataO, 0);
    checkOutput("resetFlagsInit", {validO, eolO, eofO, busyO, doneO}, 0);
    rstN = 1'b1;

    $display("[TB] ramp frame");
    applyStimulus(2'd1, 32'd0, 96'h00000002_00000001_00000000, -1, 0, 0, 0);
    $display("[TB] ramp frame with 3-cycle stall at pixel 2");
    applyStimulus(2'd1, 32'd0, 96'h00000002_00000001_00000000, 2, 3, 0, 0);
    $display("[TB] constant frame");
    applyStimulus(2'd0, 32'hA5A5A5A5, {3{32'hA5A5A5A5}}, -1, 0, 0, 0);
    $display("[TB] checker frame");
    applyStimulus(2'd3, 32'hA5A5A5A5, {3{32'hA5A5A5A5}}, -1, 0, 0, 0);
    $display("[TB] LFSR frame, seed 0");
    applyStimulus(2'd2, 32'd0, 96'h00000003_00000000_00000001, -1, 0, 0, 0);
    $display("[TB] abort at pixel 5 then restart");
    applyStimulus(2'd1, 32'd0, 96'h00000002_00000001_00000000, -1, 0, 5, 1);
    applyStimulus(2'd1, 32'd0, 96'h00000002_00000001_00000000, -1, 0, 0, 0);
    $display("[TB] reset at pixel 3 then restart");
    applyStimulus(2'd1, 32'd0, 96'h00000002_00000001_00000000, -1, 0, 3, 2);
    applyStimulus(2'd1, 32'd0, 96'h00000002_00000001_00000000, -1, 0, 0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
